// File: rtl/pipe_reg_skid_if.sv
// Handshake bundle for pipe_reg_skid: upstream valid/ready/data, downstream valid/ready/data,
// flush and occupancy. The master modport belongs to the driving side and the slave modport to the register.
interface pipe_reg_skid_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic [1:0]       count;

  modport master (
    output flush, in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, count
  );

  modport slave (
    input  flush, in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, count
  );
endinterface

// File: rtl/pipe_reg_skid.sv
// Elastic pipeline register: main entry plus a one-entry skid, so in_ready comes from a flop
// rather than from out_ready. Flush squashes held entries, and clr returns the block to empty.
module pipe_reg_skid #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic          clk,
  input logic          clr,
  pipe_reg_skid_if.slave bus
);

  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] s_data;
  logic             mv;
  logic             sv;
  logic             accept;
  logic             pop;

  // Skid full is the only reason to stall upstream, so ready never depends on out_ready.
  assign bus.in_ready  = ~sv & ~clr;
  assign accept        = bus.in_valid & bus.in_ready;
  assign pop           = mv & bus.out_ready;

  assign bus.out_valid = mv;
  assign bus.data_out  = m_data;
  assign bus.count     = {1'b0, mv} + {1'b0, sv};

  always_ff @(posedge clk) begin
    if (clr) begin
      m_data <= RESET_VAL;
      s_data <= RESET_VAL;
      mv     <= 1'b0;
      sv     <= 1'b0;
    end else if (bus.flush) begin
      // Data registers keep their contents; only the valid bits are squashed.
      mv <= 1'b0;
      sv <= 1'b0;
    end else if (!mv) begin
      if (accept) begin
        m_data <= bus.data_in;
        mv     <= 1'b1;
      end
    end else if (pop) begin
      if (sv) begin
        m_data <= s_data;
        sv     <= 1'b0;
      end else if (accept) begin
        m_data <= bus.data_in;
      end else begin
        mv <= 1'b0;
      end
    end else if (accept) begin
      s_data <= bus.data_in;
      sv     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: a queue model of the occupancy checked against the outputs on every
// falling edge, plus directed scenarios with literal expectations and a random soak.
module tb_pipe_reg_skid;
  localparam int          WIDTH = 32;
  localparam logic [31:0] RVAL  = 32'h0;

  logic clk;
  logic clr;

  pipe_reg_skid_if #(.WIDTH(WIDTH)) bus ();

  pipe_reg_skid #(.WIDTH(WIDTH), .RESET_VAL(RVAL)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];
  logic [31:0] m_head = RVAL;
  logic [31:0] seen[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare outputs, log deliveries, then advance the model by the edge that follows.
  initial begin
    bit acc;
    bit popm;
    forever begin
      @(negedge clk);
      chk("model_out_valid", {63'd0, bus.out_valid}, {63'd0, mq.size() > 0});
      chk("model_count", {62'd0, bus.count}, 64'(mq.size()));
      chk("model_data_out", {32'd0, bus.data_out}, {32'd0, m_head});
      chk("model_in_ready", {63'd0, bus.in_ready}, {63'd0, (!clr && mq.size() < 2)});
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) seen.push_back(bus.data_out);
      if (clr) begin
        mq.delete();
        m_head = RVAL;
      end else begin
        acc  = bus.in_valid && mq.size() < 2;
        popm = bus.out_ready && mq.size() > 0;
        if (popm) void'(mq.pop_front());
        if (bus.flush) mq.delete();
        else if (acc) mq.push_back(bus.data_in);
        if (mq.size() > 0) m_head = mq[0];
      end
    end
  end

  task automatic cyc(input logic c, input logic f, input logic v, input logic [31:0] d,
                     input logic r);
    clr           = c;
    bus.flush     = f;
    bus.in_valid  = v;
    bus.data_in   = d;
    bus.out_ready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [1:0] cnt, input logic ov,
                            input logic [31:0] d, input logic ir);
    chk({name, "_count"}, {62'd0, bus.count}, {62'd0, cnt});
    chk({name, "_valid"}, {63'd0, bus.out_valid}, {63'd0, ov});
    chk({name, "_data"}, {32'd0, bus.data_out}, {32'd0, d});
    chk({name, "_ready"}, {63'd0, bus.in_ready}, {63'd0, ir});
  endtask

  task automatic expect_seen(input string name, input logic [31:0] exp[$]);
    chk({name, "_n"}, 64'(seen.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < seen.size(); i++)
      chk({name, "_item"}, {32'd0, seen[i]}, {32'd0, exp[i]});
    seen.delete();
  endtask

  initial begin
    clr           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;

    // Reset then idle
    cyc(1, 0, 0, 0, 0);
    expect_out("rst1", 2'd0, 1'b0, 32'h0, 1'b0);
    cyc(1, 0, 1, 32'hFF, 1);
    expect_out("rst2", 2'd0, 1'b0, 32'h0, 1'b0);
    cyc(0, 0, 0, 0, 0);
    expect_out("rst_rel", 2'd0, 1'b0, 32'h0, 1'b1);
    seen.delete();

    // Streaming at full rate
    cyc(0, 0, 1, 32'h11, 1);
    expect_out("str1", 2'd1, 1'b1, 32'h11, 1'b1);
    cyc(0, 0, 1, 32'h22, 1);
    expect_out("str2", 2'd1, 1'b1, 32'h22, 1'b1);
    cyc(0, 0, 1, 32'h33, 1);
    expect_out("str3", 2'd1, 1'b1, 32'h33, 1'b1);
    cyc(0, 0, 0, 0, 1);
    expect_out("str_end", 2'd0, 1'b0, 32'h33, 1'b1);
    expect_seen("str_seq", '{32'h11, 32'h22, 32'h33});

    // Back-pressure fill then drain
    cyc(0, 0, 1, 32'hA, 0);
    expect_out("bp_a", 2'd1, 1'b1, 32'hA, 1'b1);
    cyc(0, 0, 1, 32'hB, 0);
    expect_out("bp_b", 2'd2, 1'b1, 32'hA, 1'b0);
    cyc(0, 0, 1, 32'hC, 0);
    expect_out("bp_stall", 2'd2, 1'b1, 32'hA, 1'b0);
    cyc(0, 0, 1, 32'hC, 1);
    expect_out("bp_pop1", 2'd1, 1'b1, 32'hB, 1'b1);
    cyc(0, 0, 1, 32'hC, 1);
    expect_out("bp_pop2", 2'd1, 1'b1, 32'hC, 1'b1);
    cyc(0, 0, 0, 0, 1);
    expect_out("bp_end", 2'd0, 1'b0, 32'hC, 1'b1);
    expect_seen("bp_seq", '{32'hA, 32'hB, 32'hC});

    // Flush at full with a simultaneous send
    cyc(0, 0, 1, 32'h5, 0);
    cyc(0, 0, 1, 32'h6, 0);
    expect_out("fl_full", 2'd2, 1'b1, 32'h5, 1'b0);
    cyc(0, 1, 1, 32'h7, 0);
    expect_out("fl_after", 2'd0, 1'b0, 32'h5, 1'b1);
    cyc(0, 0, 0, 0, 0);
    expect_out("fl_idle", 2'd0, 1'b0, 32'h5, 1'b1);
    cyc(0, 0, 1, 32'h8, 1);
    expect_out("fl_8", 2'd1, 1'b1, 32'h8, 1'b1);
    cyc(0, 0, 0, 0, 1);
    expect_out("fl_end", 2'd0, 1'b0, 32'h8, 1'b1);
    expect_seen("fl_seq", '{32'h8});

    // Reset in the middle of a full register
    cyc(0, 0, 1, 32'h21, 0);
    cyc(0, 0, 1, 32'h22, 0);
    expect_out("mr_full", 2'd2, 1'b1, 32'h21, 1'b0);
    cyc(1, 0, 1, 32'h23, 1);
    expect_out("mr_clr", 2'd0, 1'b0, 32'h0, 1'b0);
    seen.delete();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    expect_out("mr_after", 2'd0, 1'b0, 32'h0, 1'b1);
    expect_seen("mr_none", '{});

    // Random soak; the per-cycle model compare does the checking
    for (int i = 0; i < 10000; i++)
      cyc(0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), $urandom,
          ($urandom_range(0, 2) != 0));
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    expect_out("soak_end", 2'd0, 1'b0, m_head, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
